// File: rtl/fifo_param_if.sv
// fifo_param_if: producer/consumer bundle for fifo_param.
// Control, data and status of one synchronous FIFO.
interface fifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  flush;
  logic                  clr_err;
  logic                  wr_enb;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_enb;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, clr_err, wr_enb,
    output data_in, rd_enb,
    input  data_out, empty, full,
    input  almost_empty, almost_full,
    input  count, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, wr_enb,
    input  data_in, rd_enb,
    output data_out, empty, full,
    output almost_empty, almost_full,
    output count, overflow, underflow
  );
endinterface

// File: rtl/fifo_param.sv
// fifo_param: parameterised single-clock FIFO.
// Standard or FWFT read, flush, sticky error flags.
module fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input logic         clk,
  input logic         rst,
  fifo_param_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] L_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] L_AF   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] L_AE   = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_ovf;
  logic                  r_udf;

  logic w_empty;
  logic w_full;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_run;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == L_FULL);
  assign w_run    = rst & ~bus.flush;
  assign w_wr_acc = bus.wr_enb & ~w_full;
  assign w_rd_acc = bus.rd_enb & ~w_empty;

  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_empty = (r_count <= L_AE);
  assign bus.almost_full  = (r_count >= L_AF);
  assign bus.count        = r_count;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_udf;

  // Storage array; never reset, written only on accepted writes.
  always_ff @(posedge clk) begin
    if (w_run && w_wr_acc)
      r_mem[r_wr_ptr] <= bus.data_in;
  end

  // Pointers and occupancy; flush rewinds, both ops keep count.
  always_ff @(posedge clk) begin
    if (!rst || bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky errors; a new error wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (!bus.flush) begin
      r_ovf <= (r_ovf & ~bus.clr_err)
             | (bus.wr_enb & w_full);
      r_udf <= (r_udf & ~bus.clr_err)
             | (bus.rd_enb & w_empty);
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.data_out = r_mem[r_rd_ptr];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] r_dout;

    // Registered read port; holds between accepted reads.
    always_ff @(posedge clk) begin
      if (!rst)
        r_dout <= '0;
      else if (w_run && w_rd_acc)
        r_dout <= r_mem[r_rd_ptr];
    end

    assign bus.data_out = r_dout;
  end
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed checks of fifo_param.
// Standard-mode instance plus one FWFT instance.
module tb_fifo_param;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();
  fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b2 ();

  fifo_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)
  ) u_std (
    .clk(clk), .rst(rst), .bus(b1)
  );

  fifo_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .bus(b2)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle1();
    b1.wr_enb  = 1'b0;
    b1.rd_enb  = 1'b0;
    b1.flush   = 1'b0;
    b1.clr_err = 1'b0;
  endtask

  initial begin
    idle1();
    b1.data_in = 8'h00;
    b2.flush   = 1'b0;
    b2.clr_err = 1'b0;
    b2.wr_enb  = 1'b0;
    b2.rd_enb  = 1'b0;
    b2.data_in = 8'h00;

    // reset held with write requested
    rst = 1'b0;
    b1.wr_enb  = 1'b1;
    b1.data_in = 8'h55;
    tick();
    tick();
    chk("rst_count", b1.count, 0);
    chk("rst_empty", b1.empty, 1);
    chk("rst_full", b1.full, 0);
    chk("rst_ae", b1.almost_empty, 1);
    chk("rst_af", b1.almost_full, 0);
    chk("rst_dout", b1.data_out, 0);
    chk("rst_ovf", b1.overflow, 0);
    chk("rst_udf", b1.underflow, 0);
    chk("rst_cnt2", b2.count, 0);
    idle1();
    rst = 1'b1;
    tick();
    chk("rst_nowr", b1.count, 0);

    // fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      b1.wr_enb  = 1'b1;
      b1.data_in = 8'(i);
      tick();
      chk("fill_cnt", b1.count, i + 1);
      chk("fill_af", b1.almost_full,
          (i + 1 >= 14) ? 1 : 0);
      chk("fill_full", b1.full,
          (i + 1 == 16) ? 1 : 0);
    end
    idle1();

    // drain in order
    for (int i = 0; i < 16; i++) begin
      b1.rd_enb = 1'b1;
      tick();
      chk("drain_dat", b1.data_out, i);
      chk("drain_cnt", b1.count, 15 - i);
    end
    idle1();
    chk("drain_empty", b1.empty, 1);
    chk("drain_ae", b1.almost_empty, 1);

    // preload 10 words 0x40..0x49
    for (int i = 0; i < 10; i++) begin
      b1.wr_enb  = 1'b1;
      b1.data_in = 8'(8'h40 + i);
      tick();
    end
    chk("pre_cnt", b1.count, 10);

    // 30 cycles read+write across wrap
    for (int i = 0; i < 30; i++) begin
      b1.wr_enb  = 1'b1;
      b1.rd_enb  = 1'b1;
      b1.data_in = 8'(8'h4A + i);
      tick();
      chk("wrap_cnt", b1.count, 10);
      chk("wrap_dat", b1.data_out, 8'h40 + i);
    end
    idle1();

    // top up to full: holds 0x5E..0x6D
    for (int i = 0; i < 6; i++) begin
      b1.wr_enb  = 1'b1;
      b1.data_in = 8'(8'h68 + i);
      tick();
    end
    idle1();
    chk("top_full", b1.full, 1);

    // both enables while full
    b1.wr_enb  = 1'b1;
    b1.rd_enb  = 1'b1;
    b1.data_in = 8'hEE;
    tick();
    idle1();
    chk("fb_cnt", b1.count, 15);
    chk("fb_ovf", b1.overflow, 1);
    chk("fb_dat", b1.data_out, 8'h5E);
    b1.clr_err = 1'b1;
    tick();
    idle1();
    chk("ovf_clr", b1.overflow, 0);

    // drain remaining 15; 0xEE must not appear
    for (int i = 0; i < 15; i++) begin
      b1.rd_enb = 1'b1;
      tick();
      chk("dr2_dat", b1.data_out, 8'h5F + i);
    end
    idle1();
    chk("dr2_empty", b1.empty, 1);

    // both enables while empty
    b1.wr_enb  = 1'b1;
    b1.rd_enb  = 1'b1;
    b1.data_in = 8'h77;
    tick();
    idle1();
    chk("eb_cnt", b1.count, 1);
    chk("eb_udf", b1.underflow, 1);
    chk("eb_ovf", b1.overflow, 0);
    b1.clr_err = 1'b1;
    tick();
    idle1();
    chk("udf_clr", b1.underflow, 0);
    b1.rd_enb = 1'b1;
    tick();
    idle1();
    chk("eb_dat", b1.data_out, 8'h77);
    chk("eb_emp", b1.empty, 1);

    // underflow sets and persists
    b1.rd_enb = 1'b1;
    tick();
    idle1();
    chk("udf_set", b1.underflow, 1);
    chk("udf_dout", b1.data_out, 8'h77);
    tick();
    chk("udf_hold", b1.underflow, 1);
    b1.clr_err = 1'b1;
    tick();
    idle1();
    chk("udf_clr2", b1.underflow, 0);
    b1.clr_err = 1'b1;
    b1.rd_enb  = 1'b1;
    tick();
    idle1();
    chk("udf_race", b1.underflow, 1);

    // flush with 7 words and a write request
    for (int i = 0; i < 7; i++) begin
      b1.wr_enb  = 1'b1;
      b1.data_in = 8'(8'h80 + i);
      tick();
    end
    chk("fl_pre", b1.count, 7);
    b1.wr_enb  = 1'b1;
    b1.data_in = 8'h99;
    b1.flush   = 1'b1;
    tick();
    idle1();
    chk("fl_cnt", b1.count, 0);
    chk("fl_empty", b1.empty, 1);
    chk("fl_udf", b1.underflow, 1);
    chk("fl_ovf", b1.overflow, 0);
    chk("fl_dout", b1.data_out, 8'h77);
    b1.wr_enb  = 1'b1;
    b1.data_in = 8'h3C;
    tick();
    idle1();
    chk("fl_wr", b1.count, 1);
    b1.rd_enb = 1'b1;
    tick();
    idle1();
    chk("fl_rd", b1.data_out, 8'h3C);
    chk("fl_end", b1.empty, 1);

    // FWFT: word falls through without a read
    b2.wr_enb  = 1'b1;
    b2.data_in = 8'hA5;
    tick();
    b2.wr_enb = 1'b0;
    chk("fw_dat", b2.data_out, 8'hA5);
    chk("fw_emp", b2.empty, 0);
    tick();
    chk("fw_hold", b2.data_out, 8'hA5);
    b2.rd_enb = 1'b1;
    tick();
    b2.rd_enb = 1'b0;
    chk("fw_pop", b2.empty, 1);
    b2.wr_enb  = 1'b1;
    b2.data_in = 8'h11;
    tick();
    b2.data_in = 8'h22;
    tick();
    b2.wr_enb = 1'b0;
    chk("fw_d1", b2.data_out, 8'h11);
    b2.rd_enb = 1'b1;
    tick();
    b2.rd_enb = 1'b0;
    chk("fw_d2", b2.data_out, 8'h22);
    chk("fw_c1", b2.count, 1);

    // reset mid-transfer drops contents
    b2.wr_enb  = 1'b1;
    b2.data_in = 8'h33;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    b2.wr_enb = 1'b0;
    chk("mid_rst", b2.count, 0);
    chk("mid_emp", b2.empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_param.md
# fifo_param

Parameterised synchronous FIFO, the successor to the fixed 8-bit × 8-entry buffer. Width, depth and almost-full/almost-empty thresholds are generics. It adds a selectable first-word-fall-through (FWFT) read mode, a synchronous flush, and sticky overflow/underflow error flags. It sits between a producer and a consumer on a single clock domain and serves as the common buffer for the verification benches and datapath blocks.

## Interface
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 4, pointer width; depth DEPTH = 2**ADDR_WIDTH (16).
- AF_LEVEL, DEPTH-2 (14), almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low (one clock; reset is synchronous and active-low).
- flush  in  1  synchronous clear of contents; active-high.
- clr_err  in  1  clears overflow/underflow; active-high.
- wr_enb  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- rd_enb  in  1  read request.
- data_out  out  DATA_WIDTH  read data.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AE_LEVEL.
- almost_full  out  1  count >= AF_LEVEL.
- count  out  ADDR_WIDTH+1  number of stored words, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
- wr_acc = wr_enb & !full; rd_acc = rd_enb & !empty. Both are evaluated on the current-cycle flags.
- On wr_acc, mem[wr_ptr] <= data_in and wr_ptr increments. On rd_acc, rd_ptr increments.
- Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither are accepted. count never exceeds DEPTH or goes below 0.
- Full with wr_enb & rd_enb: only the read is accepted, count drops to DEPTH-1, and overflow sets.
- Empty with wr_enb & rd_enb: only the write is accepted, count becomes 1, and underflow sets.
- empty, full, almost_* are decoded combinationally from the count register only, so they change only on clock edges.
- Standard mode (FWFT=0): on rd_acc, data_out <= mem[rd_ptr]. Otherwise data_out holds.
- FWFT mode (FWFT=1): data_out = mem[rd_ptr] combinationally, and rd_acc pops. data_out is don't-care while empty.
- overflow <= 1 on wr_enb & full; underflow <= 1 on rd_enb & empty. Both hold until clr_err or reset.
- If clr_err and a new error occur in the same cycle, the flag stays 1.
- Priority order: rst, then flush, then normal operation.
- flush sets wr_ptr = rd_ptr = 0 and count = 0 and ignores wr_enb/rd_enb that cycle.
- flush leaves data_out and the error flags unchanged; mem contents are not cleared.
- Memory is not reset.

## Timing
- Reset values (first edge with rst=0): count=0, empty=1, full=0, almost_empty=1, almost_full=0 (AF_LEVEL>=1), overflow=0, underflow=0, pointers=0, data_out=0 in standard mode.
- A reset asserted mid-transfer discards all contents at that edge; the in-flight request is ignored.
- Write-to-count latency is 1 cycle; flags follow count in the same cycle.
- Standard read latency: the word appears on data_out 1 cycle after the rd_acc edge.
- FWFT: a word written into an empty FIFO appears on data_out 1 cycle after the write edge, when empty deasserts.
- Sustained throughput is one write and one read per cycle, with no bubbles.

## Test plan
- Reset: hold rst=0 for 2 cycles with wr_enb=1 -> count=0, empty=1, data_out=0, overflow=0; no write is accepted.
- Fill/drain (DEPTH=16, FWFT=0): write 0x00..0x0F -> full=1 and almost_full from count=14. Then 16 reads -> data_out returns 0x00..0x0F in order, each 1 cycle after its read, and empty=1 at the end.
- Wrap and simultaneous access:
  - Preload 10 words, then do 30 cycles of wr_enb=rd_enb=1 -> count stays 10; data stays in order across the pointer wrap.
  - At full with both enables -> count=15 and overflow=1.
  - At empty with both enables -> count=1 and underflow=1.
- Error flags: read while empty -> underflow=1 and it persists. Assert clr_err -> 0 next cycle. Assert clr_err together with a fresh underflow -> flag stays 1.
- Flush: with 7 words stored, assert flush with wr_enb=1 -> count=0 and empty=1 next cycle, the write is dropped, error flags are unchanged. The next write/read returns the new data.
- FWFT=1: write 0xA5 into empty -> data_out=0xA5 one cycle later with no read. Assert rd_enb -> empty=1 the following cycle.
